// File: rtl/addr_unit_rs_pkg.sv
// Shared types for the addressing unit: next-address source encoding and the
// select priority encoder.
package addr_unit_pkg;

  typedef enum logic [2:0] {
    SRC_RESET,
    SRC_RET,
    SRC_PCI,
    SRC_PC1,
    SRC_RI,
    SRC_R0,
    SRC_HOLD
  } src_e;

  typedef struct packed {
    logic reset_pc;
    logic ret;
    logic pc_plus_i;
    logic pc_plus_1;
    logic r_plus_i;
    logic r_plus_0;
  } sel_t;

  // Highest-priority active select wins; no select means hold the PC.
  function automatic src_e prio_encode(sel_t sel);
    src_e src;
    src = SRC_HOLD;
    if (sel.reset_pc)       src = SRC_RESET;
    else if (sel.ret)       src = SRC_RET;
    else if (sel.pc_plus_i) src = SRC_PCI;
    else if (sel.pc_plus_1) src = SRC_PC1;
    else if (sel.r_plus_i)  src = SRC_RI;
    else if (sel.r_plus_0)  src = SRC_R0;
    return src;
  endfunction

endpackage

// File: rtl/addr_unit_rs_if.sv
// Controller/memory-side bus of the addressing unit.
interface addr_unit_rs_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned IW = 8
);
  logic [AW-1:0] Rside;
  logic [IW-1:0] Iside;
  logic          ResetPC;
  logic          PCplusI;
  logic          PCplus1;
  logic          RplusI;
  logic          Rplus0;
  logic          Call;
  logic          Ret;
  logic          PCenable;
  logic [AW-1:0] Address;
  logic [AW-1:0] PCout;
  logic          StackEmpty;
  logic          StackFull;
  logic          StackErr;

  modport master (
    output Rside, Iside, ResetPC, PCplusI, PCplus1, RplusI, Rplus0, Call, Ret, PCenable,
    input  Address, PCout, StackEmpty, StackFull, StackErr
  );

  modport slave (
    input  Rside, Iside, ResetPC, PCplusI, PCplus1, RplusI, Rplus0, Call, Ret, PCenable,
    output Address, PCout, StackEmpty, StackFull, StackErr
  );
endinterface

// File: rtl/addr_unit_rs_ret_stack.sv
// Hardware return-address stack: LIFO with clear, registered status and a
// one-cycle error pulse on overflow/underflow attempts.
module ret_stack #(
  parameter int unsigned AW    = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_data,
  output logic [AW-1:0] top,
  output logic          empty,
  output logic          full,
  output logic          err_c
);

  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned SPW  = IDXW + 1;

  logic [SPW-1:0] sp_q, sp_d;
  logic           empty_q, empty_d;
  logic           full_q, full_d;
  logic           push_ok;
  logic [AW-1:0]  mem_q [DEPTH];

  // Pop has precedence over push; clear overrides both.
  always_comb begin
    sp_d    = sp_q;
    push_ok = 1'b0;
    err_c   = 1'b0;
    if (clear) begin
      sp_d = '0;
    end else if (pop) begin
      if (empty_q) err_c = 1'b1;
      else         sp_d  = sp_q - SPW'(1);
    end else if (push) begin
      if (full_q) begin
        err_c = 1'b1;
      end else begin
        push_ok = 1'b1;
        sp_d    = sp_q + SPW'(1);
      end
    end
    empty_d = (sp_d == '0);
    full_d  = (sp_d == SPW'(DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q    <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  // Entry storage needs no reset; only sp defines validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[sp_q[IDXW-1:0]] <= push_data;
  end

  assign top   = mem_q[IDXW'(sp_q - SPW'(1))];
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/addr_unit_rs.sv
// Addressing unit: PC register, prioritised next-address mux with
// sign-extended immediates, and call/return stack with sticky error flag.
module addr_unit_rs
  import addr_unit_pkg::*;
#(
  parameter int unsigned AW        = 16,
  parameter int unsigned IW        = 8,
  parameter int unsigned DEPTH     = 8,
  parameter logic [AW-1:0] RESET_VEC = '0
) (
  input logic           clk,
  input logic           rst_n,
  addr_unit_rs_if.slave bus
);

  sel_t          sel;
  src_e          src;
  logic [AW-1:0] ix;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pc_inc;
  logic [AW-1:0] address_c;
  logic [AW-1:0] stk_top;
  logic          stk_empty, stk_full, stk_err_c;
  logic          push, pop;
  logic          stack_err_q, stack_err_d;

  assign ix     = AW'($signed(bus.Iside));
  assign pc_inc = pc_q + AW'(1);

  // Next-address selection; an empty stack makes Ret fall through.
  always_comb begin
    sel.reset_pc  = bus.ResetPC;
    sel.ret       = bus.Ret;
    sel.pc_plus_i = bus.PCplusI;
    sel.pc_plus_1 = bus.PCplus1;
    sel.r_plus_i  = bus.RplusI;
    sel.r_plus_0  = bus.Rplus0;
    src           = prio_encode(sel);
    address_c     = pc_q;
    case (src)
      SRC_RESET: address_c = RESET_VEC;
      SRC_RET:   address_c = stk_empty ? pc_inc : stk_top;
      SRC_PCI:   address_c = pc_q + ix;
      SRC_PC1:   address_c = pc_inc;
      SRC_RI:    address_c = bus.Rside + ix;
      SRC_R0:    address_c = bus.Rside;
      default:   address_c = pc_q;
    endcase
  end

  // Stack commands only commit with PCenable; ResetPC clears regardless.
  always_comb begin
    push        = bus.Call & bus.PCenable & ~bus.Ret & ~bus.ResetPC;
    pop         = bus.Ret & bus.PCenable & ~bus.ResetPC;
    pc_d        = bus.PCenable ? address_c : pc_q;
    stack_err_d = stack_err_q;
    if (bus.ResetPC)    stack_err_d = 1'b0;
    else if (stk_err_c) stack_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_VEC;
      stack_err_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      stack_err_q <= stack_err_d;
    end
  end

  ret_stack #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (bus.ResetPC),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (stk_top),
    .empty     (stk_empty),
    .full      (stk_full),
    .err_c     (stk_err_c)
  );

  assign bus.Address    = address_c;
  assign bus.PCout      = pc_q;
  assign bus.StackEmpty = stk_empty;
  assign bus.StackFull  = stk_full;
  assign bus.StackErr   = stack_err_q;

endmodule

// File: tb/tb_addr_unit_rs.sv
// Directed bench for addr_unit_rs: queue-based reference model checked every
// cycle, plus hand-computed literal expectations.
module tb_addr_unit_rs;

  localparam int unsigned AW    = 16;
  localparam int unsigned IW    = 8;
  localparam int unsigned DEPTH = 8;
  localparam logic [15:0] RV    = 16'h0000;

  logic clk;
  logic rst_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  addr_unit_rs_if #(.AW(AW), .IW(IW)) bus ();

  addr_unit_rs #(
    .AW        (AW),
    .IW        (IW),
    .DEPTH     (DEPTH),
    .RESET_VEC (RV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: PC as an integer, return stack as a queue.
  logic [15:0] m_pc = RV;
  logic [15:0] m_stk[$];
  bit          m_err = 1'b0;

  function automatic logic [15:0] m_addr();
    int ix;
    ix = int'($signed(bus.Iside));
    if (bus.ResetPC)      return RV;
    else if (bus.Ret)     return (m_stk.size() > 0) ? m_stk[$] : 16'(int'(m_pc) + 1);
    else if (bus.PCplusI) return 16'(int'(m_pc) + ix);
    else if (bus.PCplus1) return 16'(int'(m_pc) + 1);
    else if (bus.RplusI)  return 16'(int'(bus.Rside) + ix);
    else if (bus.Rplus0)  return bus.Rside;
    else                  return m_pc;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [15:0] a;
    if (!rst_n) begin
      m_pc  = RV;
      m_stk.delete();
      m_err = 1'b0;
    end else begin
      a = m_addr();
      if (bus.ResetPC) begin
        m_stk.delete();
        m_err = 1'b0;
        if (bus.PCenable) m_pc = a;
      end else if (bus.PCenable) begin
        if (bus.Ret) begin
          if (m_stk.size() > 0) void'(m_stk.pop_back());
          else                  m_err = 1'b1;
        end else if (bus.Call) begin
          if (m_stk.size() < DEPTH) m_stk.push_back(16'(int'(m_pc) + 1));
          else                      m_err = 1'b1;
        end
        m_pc = a;
      end
    end
  end

  // Compare DUT against the model mid-cycle, away from the active edge.
  always @(negedge clk) begin
    check("cmp_Address",    32'(bus.Address),    32'(m_addr()));
    check("cmp_PCout",      32'(bus.PCout),      32'(m_pc));
    check("cmp_StackEmpty", 32'(bus.StackEmpty), 32'(m_stk.size() == 0));
    check("cmp_StackFull",  32'(bus.StackFull),  32'(m_stk.size() == DEPTH));
    check("cmp_StackErr",   32'(bus.StackErr),   32'(m_err));
  end

  task automatic clr();
    bus.ResetPC  = 1'b0;
    bus.PCplusI  = 1'b0;
    bus.PCplus1  = 1'b0;
    bus.RplusI   = 1'b0;
    bus.Rplus0   = 1'b0;
    bus.Call     = 1'b0;
    bus.Ret      = 1'b0;
    bus.PCenable = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp;
    rst_n     = 1'b1;
    bus.Rside = '0;
    bus.Iside = '0;
    clr();
    #1 rst_n = 1'b0;
    #2;
    check("rst_PCout", 32'(bus.PCout), 32'h0000);
    check("rst_Address", 32'(bus.Address), 32'h0000);
    check("rst_Empty", 32'(bus.StackEmpty), 32'h1);
    check("rst_Full", 32'(bus.StackFull), 32'h0);
    check("rst_Err", 32'(bus.StackErr), 32'h0);
    #9 rst_n = 1'b1;

    // Sequential fetch
    clr(); bus.PCplus1 = 1'b1; bus.PCenable = 1'b1;
    #1 check("seq_addr0", 32'(bus.Address), 32'h0001);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check("seq_pc", 32'(bus.PCout), 32'(i));
      check("seq_addr", 32'(bus.Address), 32'(i + 1));
    end

    // Signed immediate and wrap-around
    clr(); bus.Rplus0 = 1'b1; bus.Rside = 16'h0010; bus.PCenable = 1'b1;
    tick();
    check("imm_pc", 32'(bus.PCout), 32'h0010);
    clr(); bus.PCplusI = 1'b1; bus.Iside = 8'hFE;
    #1 check("imm_pci_neg", 32'(bus.Address), 32'h000E);
    clr(); bus.RplusI = 1'b1; bus.Rside = 16'hFFFF; bus.Iside = 8'h02;
    #1 check("imm_ri_wrap", 32'(bus.Address), 32'h0001);

    // Single call / return
    clr(); bus.Rplus0 = 1'b1; bus.Rside = 16'h0020; bus.PCenable = 1'b1;
    tick();
    clr(); bus.Call = 1'b1; bus.Rplus0 = 1'b1; bus.Rside = 16'h0100; bus.PCenable = 1'b1;
    tick();
    check("call_pc", 32'(bus.PCout), 32'h0100);
    check("call_empty", 32'(bus.StackEmpty), 32'h0);
    clr(); bus.Ret = 1'b1; bus.PCenable = 1'b1;
    #1 check("ret_addr", 32'(bus.Address), 32'h0021);
    tick();
    check("ret_pc", 32'(bus.PCout), 32'h0021);
    check("ret_empty", 32'(bus.StackEmpty), 32'h1);

    // Overflow: nine calls into an eight-deep stack
    for (int i = 0; i < 9; i++) begin
      clr(); bus.Call = 1'b1; bus.Rplus0 = 1'b1; bus.PCenable = 1'b1;
      bus.Rside = 16'h1000 + 16'(16 * i);
      tick();
      if (i == 7) begin
        check("ovf_full8", 32'(bus.StackFull), 32'h1);
        check("ovf_err8", 32'(bus.StackErr), 32'h0);
      end
    end
    check("ovf_pc9", 32'(bus.PCout), 32'h1080);
    check("ovf_err9", 32'(bus.StackErr), 32'h1);

    // Underflow: nine returns, LIFO order then fall-through
    for (int k = 0; k < 9; k++) begin
      clr(); bus.Ret = 1'b1; bus.PCenable = 1'b1;
      if (k < 7)       exp = 16'h1061 - 16'(16 * k);
      else if (k == 7) exp = 16'h0022;
      else             exp = 16'h0023;
      #1 check("unf_addr", 32'(bus.Address), 32'(exp));
      tick();
      check("unf_pc", 32'(bus.PCout), 32'(exp));
    end
    check("unf_err", 32'(bus.StackErr), 32'h1);
    check("unf_empty", 32'(bus.StackEmpty), 32'h1);

    // ResetPC without PCenable clears the flag but keeps the PC
    clr(); bus.ResetPC = 1'b1;
    tick();
    check("rpc_err", 32'(bus.StackErr), 32'h0);
    check("rpc_pc_hold", 32'(bus.PCout), 32'h0023);
    clr(); bus.ResetPC = 1'b1; bus.PCenable = 1'b1;
    tick();
    check("rpc_pc", 32'(bus.PCout), 32'(RV));

    // Call+Ret together: Ret wins, no error
    clr(); bus.Rplus0 = 1'b1; bus.Rside = 16'h0041; bus.PCenable = 1'b1;
    tick();
    clr(); bus.Call = 1'b1; bus.Rplus0 = 1'b1; bus.Rside = 16'h0200; bus.PCenable = 1'b1;
    tick();
    clr(); bus.Call = 1'b1; bus.Ret = 1'b1; bus.PCplus1 = 1'b1; bus.PCenable = 1'b1;
    #1 check("cr_addr", 32'(bus.Address), 32'h0042);
    tick();
    check("cr_pc", 32'(bus.PCout), 32'h0042);
    check("cr_empty", 32'(bus.StackEmpty), 32'h1);
    check("cr_err", 32'(bus.StackErr), 32'h0);

    // Ret without PCenable holds PC and stack
    clr(); bus.Call = 1'b1; bus.Rplus0 = 1'b1; bus.Rside = 16'h0300; bus.PCenable = 1'b1;
    tick();
    clr(); bus.Ret = 1'b1;
    tick();
    check("hold_pc", 32'(bus.PCout), 32'h0300);
    check("hold_empty", 32'(bus.StackEmpty), 32'h0);
    check("hold_addr", 32'(bus.Address), 32'h0043);

    // Asynchronous reset mid-sequence with three entries pushed
    clr(); bus.Call = 1'b1; bus.PCplus1 = 1'b1; bus.PCenable = 1'b1;
    tick();
    tick();
    clr();
    #2 rst_n = 1'b0;
    #1;
    check("arst_pc", 32'(bus.PCout), 32'(RV));
    check("arst_empty", 32'(bus.StackEmpty), 32'h1);
    check("arst_full", 32'(bus.StackFull), 32'h0);
    check("arst_err", 32'(bus.StackErr), 32'h0);
    check("arst_addr", 32'(bus.Address), 32'(RV));
    tick();
    #2 rst_n = 1'b1;
    clr(); bus.Ret = 1'b1; bus.PCenable = 1'b1;
    #1 check("arst_ret_addr", 32'(bus.Address), 32'h0001);
    tick();
    check("arst_ret_err", 32'(bus.StackErr), 32'h1);
    clr();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
